// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the register file / decode stage.
// It holds the PC, fetches 32-bit words over a req/ack handshake and presents one
// instruction at a time with its PC and the ARM-visible R15 value (PC+8).
// Branch redirects take priority and can discard an in-flight fetch.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), asynchronous active-high reset
//   imem_req_o/addr_o        fetch request and address
//   imem_ack_i/rdata_i       memory completion and instruction word
//   instr_o/instr_valid_o    instruction presented to decode
//   id_ready_i               decode accepts the instruction
//   pc_out_o, r15_o          address of instr_o and that address + 8
//   branch_taken_i/target_i  redirect request and target (bits [1:0] forced 0)
//   fetch_count_o, kill_count_o   only when FETCH_STATS_EN is defined
//
// Optional feature macro: FETCH_STATS_EN adds transfer and discard counters.

module fetch_unit #(
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [31:0]       imem_rdata_i,
   output logic [31:0]       instr_o,
   output logic              instr_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] pc_out_o,
   output logic [ADDR_W-1:0] r15_o,
`ifdef FETCH_STATS_EN
   output logic [31:0]       fetch_count_o,
   output logic [31:0]       kill_count_o,
`endif
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i
);

   typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [ADDR_W-1:0] r15_q, r15_d;
   logic              kill_q, kill_d;
   logic [ADDR_W-1:0] target;

   assign target = {branch_target_i[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StBoot;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         pc_out_q <= '0;
         r15_q    <= ADDR_W'(8);
         kill_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         pc_out_q <= pc_out_d;
         r15_q    <= r15_d;
         kill_q   <= kill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      pc_out_d = pc_out_q;
      r15_d    = r15_q;
      kill_d   = kill_q;
      unique case (state_q)
         StBoot: begin
            state_d = StFetch;
            if (branch_taken_i) begin
               pc_d   = target;
               addr_d = target;
            end
         end
         StFetch: begin
            if (branch_taken_i) begin
               pc_d = target;
               if (imem_ack_i) begin
                  addr_d = target;
                  kill_d = 1'b0;
               end else begin
                  // Outstanding request must complete at its original address.
                  kill_d = 1'b1;
               end
            end else if (imem_ack_i) begin
               if (kill_q) begin
                  kill_d = 1'b0;
                  addr_d = pc_q;
               end else begin
                  instr_d  = imem_rdata_i;
                  pc_out_d = addr_q;
                  r15_d    = addr_q + ADDR_W'(8);
                  valid_d  = 1'b1;
                  pc_d     = addr_q + ADDR_W'(4);
                  state_d  = StHold;
               end
            end
         end
         StHold: begin
            if (branch_taken_i) begin
               valid_d = 1'b0;
               pc_d    = target;
               addr_d  = target;
               state_d = StFetch;
            end else if (id_ready_i) begin
               valid_d = 1'b0;
               addr_d  = pc_q;
               state_d = StFetch;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   assign imem_req_o    = (state_q == StFetch);
   assign imem_addr_o   = addr_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign pc_out_o      = pc_out_q;
   assign r15_o         = r15_q;

`ifdef FETCH_STATS_EN
   logic        fetch_inc, kill_inc;
   logic [31:0] fetch_cnt_q, kill_cnt_q;

   assign fetch_inc = (state_q == StHold) && id_ready_i && !branch_taken_i;
   // Discarded acks (stale or redirected) and squashed held instructions.
   assign kill_inc  = ((state_q == StFetch) && imem_ack_i && (kill_q || branch_taken_i)) ||
                      ((state_q == StHold) && branch_taken_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (kill_inc)  kill_cnt_q  <= kill_cnt_q + 32'd1;
      end
   end

   assign fetch_count_o = fetch_cnt_q;
   assign kill_count_o  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic        ack, rdy, br;
   logic [31:0] tgt, rdata;
   logic        req;
   logic [31:0] addr, instr, pco, r15;
   logic        vld;
   logic [31:0] fc, kc;

   logic        ack2, rdy2;
   logic [31:0] rdata2;
   logic        req2, vld2;
   logic [31:0] addr2, instr2, pco2, r152;
   logic [31:0] fc2, kc2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst),
      .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
      .instr_o(instr), .instr_valid_o(vld), .id_ready_i(rdy),
      .pc_out_o(pco), .r15_o(r15),
`ifdef FETCH_STATS_EN
      .fetch_count_o(fc), .kill_count_o(kc),
`endif
      .branch_taken_i(br), .branch_target_i(tgt)
   );

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst2),
      .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_rdata_i(rdata2),
      .instr_o(instr2), .instr_valid_o(vld2), .id_ready_i(rdy2),
      .pc_out_o(pco2), .r15_o(r152),
`ifdef FETCH_STATS_EN
      .fetch_count_o(fc2), .kill_count_o(kc2),
`endif
      .branch_taken_i(1'b0), .branch_target_i(32'h0)
   );

`ifndef FETCH_STATS_EN
   assign fc  = '0;
   assign kc  = '0;
   assign fc2 = '0;
   assign kc2 = '0;
`endif

   typedef struct {
      logic        ack, rdy, br;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] instr, pco, r15, fc, kc;
   } vec_t;

   vec_t vec[$];

   task automatic add(input logic a, input logic r, input logic b, input logic [31:0] t,
                      input logic q, input logic [31:0] ad, input logic v,
                      input logic [31:0] in, input logic [31:0] p, input logic [31:0] r1,
                      input logic [31:0] f, input logic [31:0] k);
      vec_t e;
      e.ack = a; e.rdy = r; e.br = b; e.tgt = t;
      e.req = q; e.addr = ad; e.vld = v; e.instr = in; e.pco = p; e.r15 = r1;
      e.fc = f; e.kc = k;
      vec.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] K = 32'hA5A5_0000;

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      ack = 0; rdy = 0; br = 0; tgt = 0; rdata = 0;
      ack2 = 0; rdy2 = 0; rdata2 = 0;

      //   ack rdy br tgt      | req addr      vld instr      pco        r15        fc kc
      add(0, 0, 0, 0,          0, 32'h0,   0, 32'h0,    32'h0,   32'h8,   0, 0);
      add(1, 1, 0, 0,          1, 32'h0,   0, 32'h0,    32'h0,   32'h8,   0, 0);
      add(0, 1, 0, 0,          0, 32'h0,   1, K^32'h0,  32'h0,   32'h8,   0, 0);
      add(1, 1, 0, 0,          1, 32'h4,   0, K^32'h0,  32'h0,   32'h8,   1, 0);
      add(0, 1, 0, 0,          0, 32'h4,   1, K^32'h4,  32'h4,   32'hC,   1, 0);
      for (int i = 0; i < 3; i++)
         add(0, 1, 0, 0,       1, 32'h8,   0, K^32'h4,  32'h4,   32'hC,   2, 0);
      add(1, 1, 0, 0,          1, 32'h8,   0, K^32'h4,  32'h4,   32'hC,   2, 0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 0,       0, 32'h8,   1, K^32'h8,  32'h8,   32'h10,  2, 0);
      add(0, 1, 0, 0,          0, 32'h8,   1, K^32'h8,  32'h8,   32'h10,  2, 0);
      add(0, 1, 1, 32'h103,    1, 32'hC,   0, K^32'h8,  32'h8,   32'h10,  3, 0);
      add(0, 1, 0, 0,          1, 32'hC,   0, K^32'h8,  32'h8,   32'h10,  3, 0);
      add(1, 1, 0, 0,          1, 32'hC,   0, K^32'h8,  32'h8,   32'h10,  3, 0);
      add(1, 1, 0, 0,          1, 32'h100, 0, K^32'h8,  32'h8,   32'h10,  3, 1);
      add(0, 1, 1, 32'h200,    0, 32'h100, 1, K^32'h100, 32'h100, 32'h108, 3, 1);
      add(0, 1, 1, 32'h300,    1, 32'h200, 0, K^32'h100, 32'h100, 32'h108, 3, 2);
      add(0, 1, 1, 32'h400,    1, 32'h200, 0, K^32'h100, 32'h100, 32'h108, 3, 2);
      add(1, 1, 0, 0,          1, 32'h200, 0, K^32'h100, 32'h100, 32'h108, 3, 2);
      add(1, 1, 1, 32'h500,    1, 32'h400, 0, K^32'h100, 32'h100, 32'h108, 3, 3);
      add(1, 1, 0, 0,          1, 32'h500, 0, K^32'h100, 32'h100, 32'h108, 3, 4);
      add(0, 1, 0, 0,          0, 32'h500, 1, K^32'h500, 32'h500, 32'h508, 3, 4);
      add(0, 1, 0, 0,          1, 32'h504, 0, K^32'h500, 32'h500, 32'h508, 4, 4);

      tick(); tick();
      rst = 1'b0;

      foreach (vec[i]) begin
         ack = vec[i].ack; rdy = vec[i].rdy; br = vec[i].br; tgt = vec[i].tgt;
         rdata = vec[i].addr ^ K;
         chk($sformatf("row%0d req", i),   {31'b0, req}, {31'b0, vec[i].req});
         chk($sformatf("row%0d addr", i),  addr,  vec[i].addr);
         chk($sformatf("row%0d valid", i), {31'b0, vld}, {31'b0, vec[i].vld});
         chk($sformatf("row%0d instr", i), instr, vec[i].instr);
         chk($sformatf("row%0d pc_out", i), pco,  vec[i].pco);
         chk($sformatf("row%0d r15", i),   r15,   vec[i].r15);
`ifdef FETCH_STATS_EN
         chk($sformatf("row%0d fetch_count", i), fc, vec[i].fc);
         chk($sformatf("row%0d kill_count", i),  kc, vec[i].kc);
`endif
         tick();
      end

      // Reset asserted while a request is outstanding drops it immediately.
      ack = 0; br = 0; rdy = 0;
      chk("prereset req", {31'b0, req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst req", {31'b0, req}, 32'd0);
      chk("rst addr", addr, 32'h0);
      chk("rst valid", {31'b0, vld}, 32'd0);
      chk("rst pc_out", pco, 32'h0);
      chk("rst r15", r15, 32'h8);
`ifdef FETCH_STATS_EN
      chk("rst fetch_count", fc, 32'h0);
      chk("rst kill_count", kc, 32'h0);
`endif
      ack = 1; rdata = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      // Boot ignores the late ack; a redirect here sets the first fetch address.
      br = 1; tgt = 32'h42;
      chk("boot req", {31'b0, req}, 32'd0);
      tick();
      br = 0; ack = 1; rdata = 32'h40 ^ K;
      chk("boot-br req", {31'b0, req}, 32'd1);
      chk("boot-br addr", addr, 32'h40);
      chk("boot-br valid", {31'b0, vld}, 32'd0);
      tick();
      ack = 0;
      chk("boot-br hold valid", {31'b0, vld}, 32'd1);
      chk("boot-br instr", instr, 32'h40 ^ K);
      chk("boot-br pc_out", pco, 32'h40);
      chk("boot-br r15", r15, 32'h48);

      // Address wrap from the top of the address space.
      rst2 = 1'b0;
      chk("wrap boot req", {31'b0, req2}, 32'd0);
      chk("wrap boot addr", addr2, 32'hFFFF_FFFC);
      tick();
      ack2 = 1; rdata2 = 32'h1234_5678;
      chk("wrap fetch req", {31'b0, req2}, 32'd1);
      chk("wrap fetch addr", addr2, 32'hFFFF_FFFC);
      tick();
      ack2 = 0; rdy2 = 1;
      chk("wrap valid", {31'b0, vld2}, 32'd1);
      chk("wrap instr", instr2, 32'h1234_5678);
      chk("wrap pc_out", pco2, 32'hFFFF_FFFC);
      chk("wrap r15", r152, 32'h4);
      tick();
      chk("wrap next req", {31'b0, req2}, 32'd1);
      chk("wrap next addr", addr2, 32'h0);
      chk("wrap next valid", {31'b0, vld2}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the register file / decode stage in the ARM-subset datapath.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode, with its PC and the ARM-visible R15 value (PC+8) that drives the register file's R15 input.
- Handles branch/PC-write redirects, including discarding in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- ADDR_W, 32, PC / instruction-memory address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  ADDR_W  fetch address; stable while IMEM_REQ=1 and no ack seen.
- IMEM_ACK  in  1  memory completes request this cycle.
- IMEM_RDATA  in  32  instruction word; valid when IMEM_ACK=1.
- INSTR  out  32  instruction presented to decode.
- INSTR_VALID  out  1  INSTR/PC_OUT/R15 valid.
- ID_READY  in  1  decode accepts the instruction this cycle.
- PC_OUT  out  ADDR_W  address of INSTR.
- R15  out  ADDR_W  PC_OUT+8, feeds register-file R15 read path.
- BRANCH_TAKEN  in  1  redirect request.
- BRANCH_TARGET  in  ADDR_W  redirect address; bits [1:0] ignored, forced 0.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State=BOOT, PC=RESET_PC, IMEM_ADDR=RESET_PC, IMEM_REQ=0, INSTR=0, INSTR_VALID=0, PC_OUT=0, R15=8, KILL=0.
- States:
  - BOOT: one idle cycle, then FETCH.
  - FETCH: IMEM_REQ=1, IMEM_ADDR=registered fetch address.
  - HOLD: INSTR_VALID=1, IMEM_REQ=0.
- FETCH, IMEM_ACK=1, KILL=0, no redirect:
  - INSTR<=IMEM_RDATA, PC_OUT<=IMEM_ADDR, R15<=IMEM_ADDR+8, INSTR_VALID<=1.
  - PC<=IMEM_ADDR+4; go HOLD.
- FETCH, IMEM_ACK=1, KILL=1: discard data, KILL<=0, IMEM_ADDR<=PC, stay FETCH.
- FETCH, IMEM_ACK=0: IMEM_ADDR held, stay FETCH. No limit on wait cycles.
- HOLD, ID_READY=1:
  - Transfer complete; INSTR_VALID<=0, IMEM_ADDR<=PC, go FETCH.
  - ID_READY is ignored when INSTR_VALID=0.
- HOLD, ID_READY=0: all outputs held.
- Redirect (BRANCH_TAKEN=1) has priority over ack and transfer in every state. PC<=target in all cases:
  - BOOT: IMEM_ADDR<=target.
  - FETCH with ACK: data discarded, IMEM_ADDR<=target, stay FETCH.
  - FETCH without ACK: KILL<=1; IMEM_ADDR unchanged until the outstanding ack, then target.
  - HOLD: INSTR_VALID<=0 (instruction squashed even if ID_READY=1), IMEM_ADDR<=target, go FETCH.
- Redirect while KILL=1 and no ack: PC<=new target, KILL stays 1; the last target wins.
- Minimum latency: request to INSTR_VALID is 1 cycle after ack. Peak throughput is one instruction per 2 cycles.
- Arithmetic: PC+4 and PC+8 are modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-FETCH drops the request immediately. A late ack after reset is ignored (state BOOT).

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs FETCH_COUNT[31:0] and KILL_COUNT[31:0], both reset to 0, wrapping at 2^32.
  - FETCH_COUNT increments on every transfer to decode.
  - KILL_COUNT increments on every discarded ack and every squashed HOLD instruction.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, memory acks same cycle with data=addr^32'hA5A5_0000, ID_READY=1 -> PC_OUT 0,4,8,... every 2 cycles; R15=PC_OUT+8; INSTR matches.
- Ack delayed 3 cycles -> IMEM_ADDR stable for all 4 request cycles; INSTR_VALID rises exactly 1 cycle after ack.
- ID_READY=0 for 5 cycles in HOLD -> INSTR/PC_OUT/R15 constant, IMEM_REQ=0; first cycle with ID_READY=1 transfers exactly once.
- BRANCH_TAKEN with target 32'h100 during FETCH, ack arrives 2 cycles later -> that data is never valid; next request addr=32'h100; PC_OUT=32'h100, R15=32'h108.
- BRANCH_TAKEN in HOLD coincident with ID_READY=1 -> instruction squashed, next fetch at target; with FETCH_STATS_EN, KILL_COUNT=1 and FETCH_COUNT unchanged.
- Start at RESET_PC=32'hFFFF_FFFC -> second fetch address 0, R15 of first instruction=32'h4; RST asserted mid-wait -> IMEM_REQ=0 in the same cycle, PC=RESET_PC.
